// File: rtl/slot_pkg.sv
// Shared slot-decoding constants, types and the page-field helper.
// Used by the slot expander top and its per-slot SSR holder.
package slot_pkg;

    localparam int SLOT_CNT = 4;
    localparam int SUB_CNT  = 4;
    localparam int PG_W     = 2;
    localparam int SLOT_W   = 2;
    localparam int SEL_CNT  = SLOT_CNT * SUB_CNT;

    typedef logic [PG_W-1:0]   pg_t;
    typedef logic [SLOT_W-1:0] slot_t;

    // Picks the 2-bit slot field belonging to a page out of a PSR/SSR byte.
    function automatic slot_t page_field(input logic [7:0] r, input pg_t pg);
        slot_t f;
        case (pg)
            2'd0:    f = r[1:0];
            2'd1:    f = r[3:2];
            2'd2:    f = r[5:4];
            default: f = r[7:6];
        endcase
        return f;
    endfunction

endpackage

// File: rtl/slot_expander_if.sv
// Write/readback bundle between the expander top and one slot_ssr.
// The top drives the write strobe and data, the holder returns its SSR.
interface slot_expander_if;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] q;

    modport master (
        output we,
        output wdata,
        input  q
    );

    modport slave (
        input  we,
        input  wdata,
        output q
    );
endinterface

// File: rtl/slot_ssr.sv
// Secondary slot register for one expanded primary slot.
// Loads the CPU byte when the top raises the write strobe.
module slot_ssr
    import slot_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    slot_expander_if.slave bus
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.q <= '0;
        end else if (bus.we) begin
            bus.q <= bus.wdata;
        end
    end

endmodule

// File: rtl/slot_expander.sv
// MSX-style primary/secondary slot decoder with PSR/SSR readback
// and cartridge page chip selects.
module slot_expander
    import slot_pkg::*;
#(
    parameter logic [7:0]  PPI_PORT = 8'hA8,
    parameter logic [3:0]  EXPANDED = 4'b1000,
    parameter logic [15:0] SSR_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfrsh_n,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [3:0]  SLTSL_n,
    output logic [15:0] SUBSLT_n,
    output logic        CS1_n,
    output logic        CS2_n,
    output logic        CS01_n,
    output logic        CS12_n
);

    logic       wr_q;
    logic       run_q;
    logic       en;
    logic [7:0] psr;
    logic [7:0] ssr [SLOT_CNT];

    logic  wr_start;
    logic  psr_we;
    logic  ssr_hit;
    logic  selmem;
    logic  sel;
    logic  sub;
    logic  exp_p;
    logic  ssr_rd;
    logic  io_rd;
    pg_t   pg;
    slot_t p;
    slot_t p3;
    slot_t s;
    logic  cs0_n;
    logic  cs1_n;
    logic  cs2_n;

    // run_q masks a write start landing on the first edge after reset release.
    assign wr_start = ~wr_n & wr_q & run_q;
    assign psr_we   = wr_start & ~iorq_n & (addr[7:0] == PPI_PORT);
    assign ssr_hit  = (addr == SSR_ADDR);
    assign p3       = psr[7:6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= 1'b1;
            run_q <= 1'b0;
            en    <= 1'b0;
            psr   <= '0;
        end else begin
            wr_q  <= wr_n;
            run_q <= 1'b1;
            if (psr_we) begin
                psr <= data_in;
                en  <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < SLOT_CNT; i++) begin : g_slot
        if (EXPANDED[i]) begin : g_exp
            slot_expander_if u_if ();

            assign u_if.we = wr_start & ~mreq_n & ssr_hit & en
                           & (p3 == slot_t'(i));
            assign u_if.wdata = data_in;
            assign ssr[i]     = u_if.q;

            slot_ssr u_ssr (
                .clk     (clk),
                .reset_n (reset_n),
                .bus     (u_if.slave)
            );
        end else begin : g_flat
            assign ssr[i] = '0;
        end
    end

    assign pg     = addr[15:14];
    assign p      = en ? page_field(psr, pg) : '0;
    assign s      = page_field(ssr[p], pg);
    assign exp_p  = EXPANDED[p];
    assign selmem = ~mreq_n & rfrsh_n;

    // The SSR location of an expanded slot never selects memory.
    assign sel = reset_n & selmem & ~(ssr_hit & exp_p);
    assign sub = sel & exp_p;

    assign SLTSL_n  = ~(4'(sel) << p);
    assign SUBSLT_n = ~(16'(sub) << {p, s});

    assign ssr_rd = reset_n & ~mreq_n & ~rd_n & ssr_hit & exp_p;
    assign io_rd  = reset_n & ~iorq_n & ~rd_n
                  & (addr[7:0] == PPI_PORT);

    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        case (1'b1)
            ssr_rd: begin
                data_out = ~ssr[p];
                data_oe  = 1'b1;
            end
            io_rd: begin
                data_out = psr;
                data_oe  = 1'b1;
            end
            default: begin
                data_out = 8'h00;
                data_oe  = 1'b0;
            end
        endcase
    end

    assign cs0_n  = ~((pg == 2'd0) & ~rd_n);
    assign cs1_n  = ~((pg == 2'd1) & ~rd_n);
    assign cs2_n  = ~((pg == 2'd2) & ~rd_n);
    assign CS1_n  = cs1_n;
    assign CS2_n  = cs2_n;
    assign CS01_n = cs0_n & cs1_n;
    assign CS12_n = cs1_n & cs2_n;

endmodule

// File: tb/tb_slot_expander.sv
// Directed bench for slot_expander: PSR/SSR writes, decoding,
// readback, reset behaviour and cartridge chip selects.
module tb_slot_expander;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfrsh_n;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [3:0]  sltsl_n;
    logic [15:0] subslt_n;
    logic        cs1_n;
    logic        cs2_n;
    logic        cs01_n;
    logic        cs12_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    slot_expander dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .data_in  (data_in),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .rfrsh_n  (rfrsh_n),
        .data_out (data_out),
        .data_oe  (data_oe),
        .SLTSL_n  (sltsl_n),
        .SUBSLT_n (subslt_n),
        .CS1_n    (cs1_n),
        .CS2_n    (cs2_n),
        .CS01_n   (cs01_n),
        .CS12_n   (cs12_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle();
        mreq_n  = 1'b1;
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        rfrsh_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr    = {8'h00, a};
        data_in = d;
        iorq_n  = 1'b0;
        wr_n    = 1'b0;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        mreq_n  = 1'b0;
        wr_n    = 1'b0;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mem_rd(input logic [15:0] a);
        addr   = a;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        #2;
    endtask

    task automatic io_rd(input logic [7:0] a);
        addr   = {8'h00, a};
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        mem_rd(16'h4000);
        total_cnt++;
        if (sltsl_n !== 4'hF) $display("FAIL rst_hold_sltsl got %h exp %h", sltsl_n, 4'hF);
        else pass_cnt++;
        total_cnt++;
        if (subslt_n !== 16'hFFFF) $display("FAIL rst_hold_subslt got %h exp %h", subslt_n, 16'hFFFF);
        else pass_cnt++;
        idle();
        io_rd(8'hA8);
        total_cnt++;
        if (data_oe !== 1'b0 || data_out !== 8'h00)
            $display("FAIL rst_hold_data got oe=%b d=%h exp oe=0 d=00", data_oe, data_out);
        else pass_cnt++;
        idle();
        reset_n = 1'b1;
        mem_rd(16'h4000);
        total_cnt++;
        if (sltsl_n !== 4'b1110) $display("FAIL rst_sltsl got %b exp %b", sltsl_n, 4'b1110);
        else pass_cnt++;
        total_cnt++;
        if (subslt_n !== 16'hFFFF) $display("FAIL rst_subslt got %h exp %h", subslt_n, 16'hFFFF);
        else pass_cnt++;
        total_cnt++;
        if (data_oe !== 1'b0) $display("FAIL rst_oe got %b exp 0", data_oe);
        else pass_cnt++;
        idle();
        io_rd(8'hA8);
        total_cnt++;
        if (data_oe !== 1'b1 || data_out !== 8'h00)
            $display("FAIL rst_psr got oe=%b d=%h exp oe=1 d=00", data_oe, data_out);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_psr();
        io_write(8'hA8, 8'hC0);
        io_rd(8'hA8);
        total_cnt++;
        if (data_out !== 8'hC0 || data_oe !== 1'b1)
            $display("FAIL psr_read got oe=%b d=%h exp oe=1 d=c0", data_oe, data_out);
        else pass_cnt++;
        idle();
        mem_rd(16'hC000);
        total_cnt++;
        if (sltsl_n !== 4'b0111) $display("FAIL psr_c000_sltsl got %b exp %b", sltsl_n, 4'b0111);
        else pass_cnt++;
        total_cnt++;
        if (subslt_n !== 16'hEFFF) $display("FAIL psr_c000_subslt got %h exp %h", subslt_n, 16'hEFFF);
        else pass_cnt++;
        idle();
        mem_rd(16'h4000);
        total_cnt++;
        if (sltsl_n !== 4'b1110 || subslt_n !== 16'hFFFF)
            $display("FAIL psr_4000 got %b/%h exp 1110/ffff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_ssr();
        mem_write(16'hFFFF, 8'h40);
        mem_rd(16'hC000);
        total_cnt++;
        if (subslt_n !== 16'hDFFF) $display("FAIL ssr_c000_subslt got %h exp %h", subslt_n, 16'hDFFF);
        else pass_cnt++;
        idle();
        mem_rd(16'hFFFF);
        total_cnt++;
        if (data_out !== 8'hBF || data_oe !== 1'b1)
            $display("FAIL ssr_read got oe=%b d=%h exp oe=1 d=bf", data_oe, data_out);
        else pass_cnt++;
        total_cnt++;
        if (sltsl_n !== 4'hF || subslt_n !== 16'hFFFF)
            $display("FAIL ssr_read_sel got %h/%h exp f/ffff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
        io_write(8'hA8, 8'hFC);
        mem_rd(16'h4000);
        total_cnt++;
        if (sltsl_n !== 4'b0111 || subslt_n !== 16'hEFFF)
            $display("FAIL ssr_p1 got %b/%h exp 0111/efff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
        mem_rd(16'h0000);
        total_cnt++;
        if (sltsl_n !== 4'b1110 || subslt_n !== 16'hFFFF)
            $display("FAIL ssr_p0 got %b/%h exp 1110/ffff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_nonexp();
        io_write(8'hA8, 8'h40);
        mem_write(16'hFFFF, 8'h55);
        mem_rd(16'hFFFF);
        total_cnt++;
        if (sltsl_n !== 4'b1101) $display("FAIL nx_sltsl got %b exp %b", sltsl_n, 4'b1101);
        else pass_cnt++;
        total_cnt++;
        if (data_oe !== 1'b0 || data_out !== 8'h00 || subslt_n !== 16'hFFFF)
            $display("FAIL nx_data got oe=%b d=%h sub=%h exp 0/00/ffff", data_oe, data_out, subslt_n);
        else pass_cnt++;
        idle();
        io_write(8'hA8, 8'hC0);
        mem_rd(16'hFFFF);
        total_cnt++;
        if (data_out !== 8'hBF) $display("FAIL nx_ssr_kept got %h exp %h", data_out, 8'hBF);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        io_write(8'hA8, 8'h00);
        io_write(8'hA8, 8'hC0);
        mem_write(16'hFFFF, 8'h80);
        mem_rd(16'hC000);
        total_cnt++;
        if (subslt_n !== 16'hBFFF || sltsl_n !== 4'b0111)
            $display("FAIL b2b_sel got %b/%h exp 0111/bfff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
        mem_rd(16'hFFFF);
        total_cnt++;
        if (data_out !== 8'h7F) $display("FAIL b2b_read got %h exp %h", data_out, 8'h7F);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_hold_wr();
        logic [7:0] vals [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        addr   = 16'h00A8;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = vals[i];
            @(posedge clk);
            #1;
        end
        idle();
        io_rd(8'hA8);
        total_cnt++;
        if (data_out !== 8'h12) $display("FAIL hold_wr got %h exp %h", data_out, 8'h12);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_async_reset();
        io_write(8'hA8, 8'hFF);
        io_rd(8'hA8);
        total_cnt++;
        if (data_out !== 8'hFF) $display("FAIL ar_pre got %h exp %h", data_out, 8'hFF);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (data_oe !== 1'b0 || data_out !== 8'h00)
            $display("FAIL ar_during got oe=%b d=%h exp 0/00", data_oe, data_out);
        else pass_cnt++;
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if (data_oe !== 1'b1 || data_out !== 8'h00)
            $display("FAIL ar_psr got oe=%b d=%h exp 1/00", data_oe, data_out);
        else pass_cnt++;
        iorq_n = 1'b1;
        addr   = 16'hC000;
        mreq_n = 1'b0;
        #1;
        total_cnt++;
        if (sltsl_n !== 4'b1110) $display("FAIL ar_en got %b exp %b", sltsl_n, 4'b1110);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_release_write();
        reset_n = 1'b0;
        addr    = 16'h00A8;
        data_in = 8'h77;
        iorq_n  = 1'b0;
        wr_n    = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        io_rd(8'hA8);
        total_cnt++;
        if (data_out !== 8'h00) $display("FAIL rel_write got %h exp %h", data_out, 8'h00);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_refresh_io();
        io_write(8'hA8, 8'hC0);
        addr    = 16'hC000;
        mreq_n  = 1'b0;
        rfrsh_n = 1'b0;
        #2;
        total_cnt++;
        if (sltsl_n !== 4'hF || subslt_n !== 16'hFFFF)
            $display("FAIL refresh got %h/%h exp f/ffff", sltsl_n, subslt_n);
        else pass_cnt++;
        idle();
        io_rd(8'hA8);
        total_cnt++;
        if (sltsl_n !== 4'hF) $display("FAIL io_nosel got %h exp %h", sltsl_n, 4'hF);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_cs();
        logic [15:0] a [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h4000};
        logic        r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  e [5] = '{4'b1101, 4'b0100, 4'b1010, 4'b1111, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            addr = a[i];
            rd_n = r[i];
            #2;
            total_cnt++;
            if ({cs1_n, cs2_n, cs01_n, cs12_n} !== e[i])
                $display("FAIL cs_%0d got %b exp %b", i, {cs1_n, cs2_n, cs01_n, cs12_n}, e[i]);
            else pass_cnt++;
            idle();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = 16'h0000;
        data_in = 8'h00;
        mreq_n  = 1'b1;
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        rfrsh_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_psr();
        test_ssr();
        test_nonexp();
        test_back_to_back();
        test_hold_wr();
        test_async_reset();
        test_release_write();
        test_refresh_io();
        test_cs();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/slot_expander.md
SLOT_EXPANDER -- requirements
Module: slot_expander

Interface
REQ-001 SHALL have parameter PPI_PORT, default 8'hA8: I/O address of the primary slot register (PPI port A).
REQ-002 SHALL have parameter EXPANDED, default 4'b1000: bit n set means primary slot n carries a secondary slot register.
REQ-003 SHALL have parameter SSR_ADDR, default 16'hFFFF: memory address of the secondary slot register.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with the ports named as below.
REQ-005 SHALL have port clk, input, 1: system clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous reset, active low.
REQ-007 SHALL have port addr, input, 16: Z80 address bus.
REQ-008 SHALL have port data_in, input, 8: CPU write data.
REQ-009 SHALL have ports mreq_n, iorq_n, rd_n, wr_n, rfrsh_n, each input, 1: Z80 strobes, active low.
REQ-010 SHALL have port data_out, output, 8: read-back data.
REQ-011 SHALL have port data_oe, output, 1: data_out is valid.
REQ-012 SHALL have port SLTSL_n, output, 4: primary slot selects, active low.
REQ-013 SHALL have port SUBSLT_n, output, 16: secondary slot selects; index 4*p+s, active low.
REQ-014 SHALL have ports CS1_n, CS2_n, CS01_n, CS12_n, each output, 1: cartridge page chip selects.

Function
REQ-015 SHALL detect a write start as wr_n low in the current cycle and high in the previous cycle; previous value held in wr_q, reset value 1.
REQ-016 SHALL load PSR <= data_in on a write start with iorq_n=0 and addr[7:0]=PPI_PORT, and set en=1 in the same cycle.
REQ-017 SHALL load SSR[p] <= data_in on a write start with mreq_n=0, addr=SSR_ADDR, en=1, PSR[7:6]=p and EXPANDED[p]=1.
REQ-018 SHALL ignore a write to SSR_ADDR when the page-3 primary slot is not expanded; no register changes.
REQ-019 SHALL make any register update visible to slot decoding from the cycle after the updating edge (1-cycle latency); a write start updates a register only once.
REQ-020 SHALL compute page index pg = addr[15:14] and primary slot p = PSR[2*pg+1:2*pg] when en=1, else p = 0.
REQ-021 SHALL define selmem = ~mreq_n & rfrsh_n.
REQ-022 SHALL drive SLTSL_n[p] low only when selmem=1 and addr != SSR_ADDR (or EXPANDED[p]=0), except as stated in REQ-024; all other SLTSL_n bits stay high.
REQ-023 SHALL drive SUBSLT_n[4*p+s] low, with s = SSR[p][2*pg+1:2*pg], only when SLTSL_n[p] is low and EXPANDED[p]=1; bits for non-expanded slots stay high permanently.
REQ-024 SHALL treat a read at SSR_ADDR (mreq_n=0, rd_n=0, page-3 slot expanded) as follows: data_out = ~SSR[p], data_oe=1, SLTSL_n and SUBSLT_n all high. A read at SSR_ADDR of a non-expanded slot SHALL decode normally.
REQ-025 SHALL drive data_out = PSR and data_oe=1 on an I/O read (iorq_n=0, rd_n=0) of PPI_PORT.
REQ-026 SHALL drive data_oe=0 and data_out=8'h00 otherwise; read decode is combinational, with no clock latency.
REQ-027 SHALL keep slot selects unaffected by I/O cycles and refresh cycles (rfrsh_n=0 forces all selects high).
REQ-028 SHALL drive CS0_n = ~(pg=0 & ~rd_n), CS1_n = ~(pg=1 & ~rd_n), CS2_n = ~(pg=2 & ~rd_n), CS01_n = CS0_n & CS1_n, CS12_n = CS1_n & CS2_n, all independent of mreq_n.
REQ-029 SHALL let a PSR write that changes page-3 mapping and a following SSR_ADDR write address the new slot (1-cycle latency applies).

Reset
REQ-030 SHALL, on reset_n low and irrespective of clk, clear PSR, all SSR and en to 0 and set wr_q to 1.
REQ-031 SHALL, during reset, hold SLTSL_n=4'hF, SUBSLT_n=16'hFFFF, data_oe=0 and data_out=8'h00.
REQ-032 SHALL discard a write start coincident with reset release; en=0 resumes all-pages-to-slot-0 decoding.

Structure
REQ-033 SHALL place the page/slot field width constants, slot count (4) and subslot count (4) in shared package slot_pkg.
REQ-034 SHALL instantiate one sub-module, slot_ssr, per expanded slot (generate on EXPANDED); each holds one 8-bit SSR and its write enable.

Verification
REQ-035 SHALL verify: after reset, memory read 0x4000 -> SLTSL_n=4'b1110, SUBSLT_n=16'hFFFF, data_oe=0.
REQ-036 SHALL verify: I/O write 0xA8 <= 8'hC0, then memory read 0xC000 -> SLTSL_n=4'b0111, SUBSLT_n[12]=0.
REQ-037 SHALL verify: with PSR=8'hC0, memory write 0xFFFF <= 8'h40, then read 0xC000 -> SUBSLT_n[13]=0; read 0xFFFF -> data_out=8'hBF, data_oe=1, SLTSL_n=4'hF.
REQ-038 SHALL verify: PSR=8'h40 (slot 1 not expanded), write 0xFFFF <= 8'h55 -> all SSR unchanged; read 0xFFFF -> SLTSL_n=4'b1101, data_oe=0.
REQ-039 SHALL verify: wr_n held low for 5 cycles on I/O 0xA8 while data_in changes -> PSR takes only the first-cycle value.
REQ-040 SHALL verify: reset_n pulsed low mid-cycle after PSR=8'hFF -> PSR=0 and en=0 immediately, without waiting for clk; rfrsh_n=0 with mreq_n=0 -> SLTSL_n=4'hF.
